// File: rtl/sample_sequencer.sv
// SPI sample capture and filter/DAC/peak sequencing.
// Frames arrive on an asynchronous SPI link; each accepted frame drives one filter/DAC/peak pass.
`timescale 1ns/1ps
module sample_sequencer #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned TIMEOUT    = 4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sck,
   input  logic        sdo,
   input  logic        filt_done,
   input  logic        dac_busy,
   output logic [9:0]  sample,
   output logic        filt_start,
   output logic        dac_start,
   output logic        peak_en,
   output logic        frame_err,
   output logic        overrun,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CntW  = $clog2(FRAME_BITS);
   localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

   localparam logic [CntW-1:0]  LastBit  = CntW'(FRAME_BITS - 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] FILTER   = 2'd1;
   localparam logic [1:0] WAIT_DAC = 2'd2;
   localparam logic [1:0] PEAK     = 2'd3;

   logic sck_meta_q, sck_sync_q, sck_prev_q;
   logic sdo_meta_q, sdo_sync_q;

   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] frame_word;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IdleW-1:0]      idle_q, idle_d;

   logic sck_rise;
   logic frame_done;
   logic timeout;

   logic [1:0]  state_q, state_d;
   logic [9:0]  sample_q, sample_d;
   logic        filt_start_q, filt_start_d;
   logic        dac_start_q, dac_start_d;
   logic        peak_en_q, peak_en_d;
   logic        frame_err_q;
   logic        overrun_q, overrun_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic unused_msb;
   assign unused_msb = shift_q[FRAME_BITS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_meta_q <= 1'b0;
         sck_sync_q <= 1'b0;
         sck_prev_q <= 1'b0;
         sdo_meta_q <= 1'b0;
         sdo_sync_q <= 1'b0;
      end else begin
         sck_meta_q <= sck;
         sck_sync_q <= sck_meta_q;
         sck_prev_q <= sck_sync_q;
         sdo_meta_q <= sdo;
         sdo_sync_q <= sdo_meta_q;
      end
   end

   assign sck_rise   = sck_sync_q & ~sck_prev_q;
   assign frame_word = {shift_q[FRAME_BITS-2:0], sdo_sync_q};
   assign frame_done = sck_rise && (bit_cnt_q == LastBit);
   // An edge in the same cycle always wins over the idle timeout.
   assign timeout    = !sck_rise && (bit_cnt_q != '0) && (idle_q == IdleLast);

   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      idle_d    = idle_q;
      if (sck_rise) begin
         shift_d   = frame_word;
         idle_d    = '0;
         bit_cnt_d = frame_done ? '0 : bit_cnt_q + CntW'(1);
      end else if (bit_cnt_q != '0) begin
         if (timeout) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            idle_d    = '0;
         end else begin
            idle_d = idle_q + IdleW'(1);
         end
      end else begin
         idle_d = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      sample_d     = sample_q;
      filt_start_d = 1'b0;
      dac_start_d  = 1'b0;
      peak_en_d    = 1'b0;
      overrun_d    = overrun_q;
      if (frame_done && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (frame_done) begin
               sample_d     = frame_word[9:0];
               filt_start_d = 1'b1;
               state_d      = FILTER;
            end
         end
         FILTER: begin
            // filt_done is ignored during the filt_start cycle itself.
            if (filt_done && !filt_start_q) begin
               if (dac_busy) begin
                  state_d = WAIT_DAC;
               end else begin
                  dac_start_d = 1'b1;
                  state_d     = PEAK;
               end
            end
         end
         WAIT_DAC: begin
            if (!dac_busy) begin
               dac_start_d = 1'b1;
               state_d     = PEAK;
            end
         end
         PEAK: begin
            peak_en_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign frame_cnt_d = (state_q == PEAK) ? frame_cnt_q + 16'd1 : frame_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         idle_q       <= '0;
         state_q      <= IDLE;
         sample_q     <= '0;
         filt_start_q <= 1'b0;
         dac_start_q  <= 1'b0;
         peak_en_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         idle_q       <= idle_d;
         state_q      <= state_d;
         sample_q     <= sample_d;
         filt_start_q <= filt_start_d;
         dac_start_q  <= dac_start_d;
         peak_en_q    <= peak_en_d;
         frame_err_q  <= timeout;
         overrun_q    <= overrun_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign sample     = sample_q;
   assign filt_start = filt_start_q;
   assign dac_start  = dac_start_q;
   assign peak_en    = peak_en_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
